// File: rtl/logic_op_pipe.sv
// logic_op_pipe: registered, parametrised bitwise-op stage.
//
// Computes OR / AND / XOR / NOR of two WIDTH-bit operands and presents the
// result one cycle after acceptance. In accumulate mode operand A is folded
// into a running accumulator instead of being combined with operand B.
// A saturating counter records how many beats have been accepted.
//
// Optional build feature, enabled by defining LOGIC_OP_PIPE_PARITY_EN:
//   adds output P, the even-parity bit (^O) of the registered result,
//   updated together with O and reset to 0. When the macro is not defined,
//   port P does not exist and everything else behaves identically.
//
// Handshake (both sides): a beat transfers on a rising edge where the
// producer's valid and the consumer's ready are both 1. valid, once raised,
// is held with stable data until that transfer. ready may be raised or
// dropped at any time. Here in_ready = !out_valid || out_ready. It is purely
// combinational and never looks at in_valid, so a full output slot only
// accepts a new beat in the same cycle that the slot drains.

module logic_op_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   input  logic             acc_en,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] O,
   output logic             Z,
`ifdef LOGIC_OP_PIPE_PARITY_EN
   output logic [CNT_W-1:0] beats,
   output logic             P
`else
   output logic [CNT_W-1:0] beats
`endif
);

   // Operation encoding on the op input
   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   localparam logic [CNT_W-1:0] BEATS_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] acc;       // running accumulator
   logic [WIDTH-1:0] acc_src;   // accumulator value seen by this beat
   logic [WIDTH-1:0] lhs;       // first operand of the selected op
   logic [WIDTH-1:0] rhs;       // second operand of the selected op
   logic [WIDTH-1:0] result;    // value that O takes on an accepted beat
   logic             accept;    // a beat transfers at the next edge

   // Input side is ready whenever the output slot is empty or draining now
   always_comb begin
      in_ready = !out_valid || out_ready;
      accept   = in_valid && in_ready;
   end

   // Operand selection and the bitwise op itself.
   // A clear in the same cycle as an accumulate beat makes the fold start
   // from zero instead of the stored accumulator.
   always_comb begin
      acc_src = clear ? '0 : acc;
      lhs     = A;
      rhs     = B;
      if (acc_en) begin
         lhs = acc_src;
         rhs = A;
      end
      result = '0;
      case (op)
         OP_OR:   result = lhs | rhs;
         OP_AND:  result = lhs & rhs;
         OP_XOR:  result = lhs ^ rhs;
         OP_NOR:  result = ~(lhs | rhs);
         default: result = '0;
      endcase
   end

   // Accumulator: advances only on accepted accumulate beats; clear zeroes it
   // whenever it is not itself being loaded by an accumulate beat
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (accept && acc_en) begin
         acc <= result;
      end else if (clear) begin
         acc <= '0;
      end
   end

   // Output slot: O and Z load on accept; out_valid sets on accept and
   // clears only when the held result drains with no replacement beat
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         O         <= '0;
         Z         <= 1'b1;
      end else if (accept) begin
         out_valid <= 1'b1;
         O         <= result;
         Z         <= (result == '0);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef LOGIC_OP_PIPE_PARITY_EN
   // Parity bit travels with O so it always describes the presented result
   always_ff @(posedge clk) begin
      if (rst) begin
         P <= 1'b0;
      end else if (accept) begin
         P <= ^result;
      end
   end
`endif

   // Accepted-beat counter, sticks at its maximum instead of wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         beats <= '0;
      end else if (accept && (beats != BEATS_MAX)) begin
         beats <= beats + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: randomized and directed bench for logic_op_pipe.
// Two instances share all inputs: one with an 8-bit beat counter and one with
// a 2-bit counter so saturation is observable. Build with
// LOGIC_OP_PIPE_PARITY_EN defined to also check the parity output P.

module tb_logic_op_pipe;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [1:0]   op;
   logic         acc_en;
   logic         clear;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] O;
   logic         Z;
   logic [7:0]   beats;

   logic         in_ready2;
   logic         out_valid2;
   logic [W-1:0] O2;
   logic         Z2;
   logic [1:0]   beats2;

`ifdef LOGIC_OP_PIPE_PARITY_EN
   logic         P;
   logic         P2;
`endif

   logic [W-1:0] exp_q[$];

   int total = 0;
   int bad   = 0;

   // reference model state
   logic         seen_rst = 1'b0;
   logic         ov_m     = 1'b0;
   logic [W-1:0] acc_m    = '0;
   int           cnt_m    = 0;

   logic_op_pipe #(.WIDTH(W), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op(op), .acc_en(acc_en), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .O(O), .Z(Z),
`ifdef LOGIC_OP_PIPE_PARITY_EN
      .beats(beats), .P(P)
`else
      .beats(beats)
`endif
   );

   logic_op_pipe #(.WIDTH(W), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .A(A), .B(B), .op(op), .acc_en(acc_en), .clear(clear),
      .out_valid(out_valid2), .out_ready(out_ready), .O(O2), .Z(Z2),
`ifdef LOGIC_OP_PIPE_PARITY_EN
      .beats(beats2), .P(P2)
`else
      .beats(beats2)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [1:0] o);
      case (o)
         2'd0:    return x | y;
         2'd1:    return x & y;
         2'd2:    return x ^ y;
         default: return ~(x | y);
      endcase
   endfunction

   function automatic int sat(input int n, input int max);
      return (n > max) ? max : n;
   endfunction

   // ---------------- reference model ----------------
   // Looks at the inputs just before each rising edge, checks the current
   // handshake/counter state, then advances to what the edge should produce.
   always @(negedge clk) begin
      logic         exp_ready;
      logic [W-1:0] r;
      if (rst) begin
         ov_m     = 1'b0;
         acc_m    = '0;
         cnt_m    = 0;
         exp_q.delete();
         seen_rst = 1'b1;
      end else if (seen_rst) begin
         exp_ready = !ov_m || out_ready;
         check("in_ready", 32'(in_ready), 32'(exp_ready));
         check("out_valid", 32'(out_valid), 32'(ov_m));
         check("beats", 32'(beats), 32'(sat(cnt_m, 255)));
         check("beats_sat", 32'(beats2), 32'(sat(cnt_m, 3)));
         if (in_valid && exp_ready) begin
            cnt_m++;
            if (acc_en) begin
               r     = ref_op(clear ? '0 : acc_m, A, op);
               acc_m = r;
            end else begin
               r = ref_op(A, B, op);
               if (clear) acc_m = '0;
            end
            exp_q.push_back(r);
            ov_m = 1'b1;
         end else begin
            if (clear) acc_m = '0;
            if (ov_m && out_ready) ov_m = 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   // Whenever a result is presented it must match the oldest expected one;
   // it is retired when the downstream takes it.
   always @(negedge clk) begin
      if (!rst && seen_rst && out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL result: got O=%0h with no expected result at %0t", O, $time);
         end else begin
            check("O", 32'(O), 32'(exp_q[0]));
            check("Z", 32'(Z), 32'(exp_q[0] == '0));
`ifdef LOGIC_OP_PIPE_PARITY_EN
            check("P", 32'(P), 32'(^exp_q[0]));
`endif
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                        input logic ae, input logic cl);
      logic got;
      int   n;
      in_valid = 1'b1;
      A        = a;
      B        = b;
      op       = o;
      acc_en   = ae;
      clear    = cl;
      n        = 0;
      got      = 1'b0;
      while (!got && n < 50) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      acc_en   = 1'b0;
      clear    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b1;
      A         = 8'h55;
      B         = 8'hAA;
      op        = 2'b00;
      acc_en    = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;

      // reset held two cycles with in_valid asserted
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_O", 32'(O), 32'h0);
      check("rst_Z", 32'(Z), 32'h1);
      check("rst_beats", 32'(beats), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);
      idle(1);

      // op table, back to back
      drive(8'hA5, 8'h0F, 2'b00, 1'b0, 1'b0);
      check("optab_O_or", 32'(O), 32'hAF);
      drive(8'hA5, 8'h0F, 2'b01, 1'b0, 1'b0);
      check("optab_O_and", 32'(O), 32'h05);
      drive(8'hA5, 8'h0F, 2'b10, 1'b0, 1'b0);
      check("optab_O_xor", 32'(O), 32'hAA);
      drive(8'hA5, 8'h0F, 2'b11, 1'b0, 1'b0);
      check("optab_O_nor", 32'(O), 32'h50);
      check("optab_beats", 32'(beats), 32'd4);
      idle(2);

      // accumulate XOR, then clear alone
      drive(8'h3C, 8'h00, 2'b10, 1'b1, 1'b1);
      check("acc_O_1", 32'(O), 32'h3C);
      drive(8'hFF, 8'h00, 2'b10, 1'b1, 1'b0);
      check("acc_O_2", 32'(O), 32'hC3);
      drive(8'h3C, 8'h00, 2'b10, 1'b1, 1'b0);
      check("acc_O_3", 32'(O), 32'hFF);
      in_valid = 1'b0;
      acc_en   = 1'b0;
      clear    = 1'b1;
      @(posedge clk);
      #1;
      check("clear_O_hold", 32'(O), 32'hFF);
      drive(8'h01, 8'h00, 2'b10, 1'b1, 1'b0);
      check("acc_after_clear", 32'(O), 32'h01);
      idle(2);

      // backpressure
      drive(8'h01, 8'h02, 2'b00, 1'b0, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      A         = 8'h10;
      B         = 8'h20;
      repeat (3) begin
         @(negedge clk);
         check("stall_O", 32'(O), 32'h03);
         check("stall_in_ready", 32'(in_ready), 32'h0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("unstall_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      #1;
      check("unstall_O", 32'(O), 32'h30);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         A         = W'($urandom);
         B         = W'($urandom);
         op        = 2'($urandom_range(0, 3));
         acc_en    = 1'($urandom_range(0, 1));
         clear     = ($urandom_range(0, 7) == 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      idle(3);

      // zero flag and saturation of the 2-bit counter
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive(8'h00, 8'h00, 2'b00, 1'b0, 1'b0);
         check("zero_Z", 32'(Z), 32'h1);
         check("sat_beats2", 32'(beats2), 32'(sat(i, 3)));
      end
      idle(2);

      // reset in the middle of a stall drops the result and the accumulator
      drive(8'h81, 8'h00, 2'b00, 1'b1, 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      acc_en    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      check("midrst_O", 32'(O), 32'h0);
      out_ready = 1'b1;
      drive(8'h24, 8'h00, 2'b00, 1'b1, 1'b0);
      check("midrst_acc_zero", 32'(O), 32'h24);
      idle(1);

      // parity sample
      drive(8'h07, 8'h00, 2'b00, 1'b0, 1'b0);
      check("par_O", 32'(O), 32'h07);
`ifdef LOGIC_OP_PIPE_PARITY_EN
      check("par_P", 32'(P), 32'h1);
`endif
      idle(2);

      // drain
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Parametrised, registered successor to the team's 2-input OR gate.
- Computes a selectable bitwise op (OR/AND/XOR/NOR) on two WIDTH-bit operands.
- Optional accumulate mode folds operand A into a running register.
- Valid/ready handshake on both sides; sits between lab switch/register inputs and display/LED output logic.

Parameters:
- WIDTH, 8, operand/result width in bits (1..32)
- CNT_W, 8, width of accepted-beat counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands/op present
- in_ready  output  1  block can accept a beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B (ignored in accumulate mode)
- op  input  2  00 OR, 01 AND, 10 XOR, 11 NOR
- acc_en  input  1  accumulate mode for this beat
- clear  input  1  zero the accumulator
- out_valid  output  1  O holds an unconsumed result
- out_ready  input  1  downstream takes result
- O  output  WIDTH  registered result
- Z  output  1  registered flag, O == 0
- beats  output  CNT_W  count of accepted beats, saturating

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, O=0, Z=1, acc=0, beats=0. Reset overrides every other input, including mid-transfer; any pending result is dropped.
- in_ready = !out_valid || out_ready. This is combinational from out_valid and out_ready and does not depend on in_valid.
- Accept: in_valid && in_ready at posedge.
- Latency: exactly 1 cycle from accept to out_valid=1 with O valid.
- Throughput: one beat per cycle while out_ready=1.
- Non-accumulate beat (acc_en=0): O <= f(A,B,op) where f is A|B, A&B, A^B or ~(A|B). Accumulator unchanged.
- Accumulate beat (acc_en=1): acc <= f(acc_src, A, op) and O <= the same new value.
  - acc_src = 0 if clear is asserted the same cycle, else acc.
- clear without an accepted beat: acc <= 0. O and out_valid unchanged.
- Z <= (new O == 0), updated only when O is updated.
- out_valid:
  - set on accept;
  - cleared when out_valid && out_ready with no new accept;
  - stays 1 on simultaneous drain and accept (back-to-back).
- Stall: while out_valid=1 and out_ready=0, O, Z and out_valid hold and in_ready=0. Input beats are not accepted, so the accumulator does not advance.
- beats increments by 1 per accept and saturates at 2^CNT_W-1 with no wrap. clear does not reset beats; only rst does.
- All arithmetic is bitwise at WIDTH bits. There are no carries.

Optional Feature:
- Macro: LOGIC_OP_PIPE_PARITY_EN.
- Defined: adds output port P (1 bit), registered with O, P = ^O (even-parity bit of the result). Reset value 0.
- Undefined: port P does not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, O=0, Z=1, beats=0, in_ready=1 after release.
- Op table, WIDTH=8, out_ready=1: A=8'hA5, B=8'h0F, op=00/01/10/11 on consecutive cycles → O=AF, 05, AA, 50 on the following cycles. out_valid stays 1 throughout, beats=4.
- Accumulate XOR: clear+acc_en beat with A=8'h3C, then A=8'hFF, then A=8'h3C (op=10) → O=3C, C3, FF. Then clear alone, then acc_en beat with A=8'h01 → O=01.
- Backpressure: accept A=8'h01, B=8'h02, op=00, then hold out_ready=0 for 3 cycles with in_valid=1 and new operands → O stays 03, in_ready=0, beats unchanged. On out_ready=1 the next beat is accepted the same cycle.
- Zero flag and saturation, CNT_W=2: 5 accepts of A=B=0, op=00 → Z=1 each result, beats=3 after the 3rd accept and stays 3.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst → next cycle out_valid=0, acc=0. Parity build: O=8'h07 gives P=1.
